// File: rtl/mp_adder_ctrl_pkg.sv
// Shared types and encodings for the Montgomery adder sequencer (package mp_pkg).
package mp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADD_B   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_SUB     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] ADDEND_ZERO = 2'd0;
  localparam logic [1:0] ADDEND_B    = 2'd1;
  localparam logic [1:0] ADDEND_M    = 2'd2;
  localparam logic [1:0] ADDEND_NEGM = 2'd3;

  // bit3 set freezes the datapath chunk carry chain
  localparam logic [3:0] CHUNK_IDLE = 4'd8;

  localparam int N_CHUNKS_DEF = 5;

endpackage

// File: rtl/mp_chunk_counter.sv
// Ripple-chunk index for the carry resolve and modulus-subtract passes; wraps after the last chunk.
module mp_chunk_counter
  import mp_pkg::*;
#(
  parameter int N_CHUNKS = N_CHUNKS_DEF,
  parameter int CW       = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [CW-1:0] o_chunk,
  output logic          o_last
);

  logic [CW-1:0] r_chunk;

  assign o_chunk = r_chunk;
  assign o_last  = (r_chunk == CW'(N_CHUNKS - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_chunk <= '0;
    end else if (i_clr) begin
      r_chunk <= '0;
    end else if (i_adv) begin
      r_chunk <= o_last ? '0 : r_chunk + 1'b1;
    end
  end

endmodule

// File: rtl/mp_adder_ctrl.sv
// Sequencer for the carry-save Montgomery adder: bit-serial loop, chunked resolve, modulus subtract.
// Define MP_ADDER_CTRL_SKIP_ZERO_EN to skip ADD_B for zero multiplier bits (not constant time).
//
//   state   | meaning
//   IDLE    | waiting for start
//   ADD_B   | C <= C + (a[i] ? B : 0)
//   SHIFT   | C <= (C + (c_zero ? M : 0)) >> 1, next bit
//   RESOLVE | propagate carries chunk by chunk
//   SUB     | subtract M chunk by chunk until datapath reports done
//   DONE    | one-cycle done pulse
module mp_adder_ctrl
  import mp_pkg::*;
#(
  parameter int N_BITS   = 512,
  parameter int N_CHUNKS = N_CHUNKS_DEF,
  parameter int MAX_SUB  = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [N_BITS-1:0] i_a_op,
  input  logic              i_c_zero,
  input  logic              i_sub_done,
  output logic              o_enable_c,
  output logic              o_shift,
  output logic              o_subtract,
  output logic [3:0]        o_chunk_sel,
  output logic [1:0]        o_addend_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int BW = $clog2(N_BITS);
  localparam int SW = $clog2(MAX_SUB + 1);
  localparam int CW = 3;
`ifdef MP_ADDER_CTRL_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_BITS-1:0] r_a_sr;
  logic [BW-1:0]     r_bit_cnt;
  logic [SW-1:0]     r_sub_cnt;
  logic              r_err;
  logic [CW-1:0]     w_chunk;
  logic              w_chunk_last;
  logic              w_chunk_adv;
  logic              w_bit_last;
  logic              w_sub_limit;

  assign w_bit_last  = (r_bit_cnt == BW'(N_BITS - 1));
  assign w_sub_limit = (r_sub_cnt == SW'(MAX_SUB - 1));
  assign w_chunk_adv = (r_state == ST_RESOLVE) || (r_state == ST_SUB);

  mp_chunk_counter #(
    .N_CHUNKS (N_CHUNKS),
    .CW       (CW)
  ) u_chunk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (!w_chunk_adv),
    .i_adv   (w_chunk_adv),
    .o_chunk (w_chunk),
    .o_last  (w_chunk_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_a_sr    <= '0;
      r_bit_cnt <= '0;
      r_sub_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a_sr    <= i_a_op;
            r_bit_cnt <= '0;
            r_sub_cnt <= '0;
            r_err     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!w_bit_last) begin
            r_a_sr    <= r_a_sr >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_SUB: begin
          if (w_chunk_last && !i_sub_done) begin
            r_sub_cnt <= r_sub_cnt + 1'b1;
            if (w_sub_limit) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_enable_c   = 1'b0;
    o_shift      = 1'b0;
    o_subtract   = 1'b0;
    o_chunk_sel  = CHUNK_IDLE;
    o_addend_sel = ADDEND_ZERO;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = (SKIP_ZERO && !i_a_op[0]) ? ST_SHIFT : ST_ADD_B;
      end
      ST_ADD_B: begin
        o_enable_c   = 1'b1;
        o_addend_sel = r_a_sr[0] ? ADDEND_B : ADDEND_ZERO;
        w_state_nxt  = ST_SHIFT;
      end
      ST_SHIFT: begin
        // c_zero reflects the ADD_B result, so this select is combinational on it
        o_shift      = 1'b1;
        o_addend_sel = i_c_zero ? ADDEND_M : ADDEND_ZERO;
        if (w_bit_last)                   w_state_nxt = ST_RESOLVE;
        else if (SKIP_ZERO && !r_a_sr[1]) w_state_nxt = ST_SHIFT;
        else                              w_state_nxt = ST_ADD_B;
      end
      ST_RESOLVE: begin
        o_chunk_sel = {1'b0, w_chunk};
        if (w_chunk_last) w_state_nxt = ST_SUB;
      end
      ST_SUB: begin
        o_subtract   = 1'b1;
        o_addend_sel = ADDEND_NEGM;
        o_chunk_sel  = {1'b0, w_chunk};
        if (w_chunk_last && (i_sub_done || w_sub_limit)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_err  = r_err;

endmodule

// File: tb/tb_mp_adder_ctrl.sv
// Randomized bench for mp_adder_ctrl (N_BITS=8) against a cycle-schedule model with a toy datapath.
module tb_mp_adder_ctrl;
  localparam int NB = 8;

`ifdef MP_ADDER_CTRL_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NB-1:0] a_op;
  logic          c_zero;
  logic          sub_done;
  logic          en, sh, sb, busy, done, err;
  logic [3:0]    ch;
  logic [1:0]    ad;

  int   errors = 0;
  int   checks = 0;
  logic exp_err = 1'b0;
  logic plan_err;
  int   b_val, m_val;

  typedef struct {
    logic [11:0] exp;
    bit          cz;
    bit          sd;
  } step_t;
  step_t plan[$];

  always #5 clk = ~clk;

  mp_adder_ctrl #(.N_BITS(NB), .N_CHUNKS(5), .MAX_SUB(3)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_a_op       (a_op),
    .i_c_zero     (c_zero),
    .i_sub_done   (sub_done),
    .o_enable_c   (en),
    .o_shift      (sh),
    .o_subtract   (sb),
    .o_chunk_sel  (ch),
    .o_addend_sel (ad),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  function automatic logic [11:0] pk(logic e, logic s, logic u, logic [3:0] c,
                                     logic [1:0] a, logic b, logic d, logic r);
    return {e, s, u, c, a, b, d, r};
  endfunction

  function automatic logic [11:0] obs();
    return {en, sh, sb, ch, ad, busy, done, err};
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle outputs, plus the datapath inputs to drive, derived from the operation rules
  task automatic build_plan(input logic [NB-1:0] a, input int pass_ok);
    longint c = 0;
    bit     cz;
    bit     fin = 1'b0;
    int     p = 0;
    b_val = int'($urandom_range(0, 255));
    m_val = int'($urandom_range(0, 127)) * 2 + 1;
    plan.delete();
    plan_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (!(SKIP && !a[i])) begin
        c += a[i] ? longint'(b_val) : 64'sd0;
        plan.push_back('{pk(1'b1, 1'b0, 1'b0, 4'd8, a[i] ? 2'd1 : 2'd0, 1'b1, 1'b0, 1'b0), rnd(), rnd()});
      end
      cz = c[0];
      plan.push_back('{pk(1'b0, 1'b1, 1'b0, 4'd8, cz ? 2'd2 : 2'd0, 1'b1, 1'b0, 1'b0), cz, rnd()});
      c = (c + (cz ? longint'(m_val) : 64'sd0)) >> 1;
    end
    for (int k = 0; k < 5; k++)
      plan.push_back('{pk(1'b0, 1'b0, 1'b0, 4'(k), 2'd0, 1'b1, 1'b0, 1'b0), rnd(), rnd()});
    while (!fin) begin
      p++;
      for (int k = 0; k < 5; k++)
        plan.push_back('{pk(1'b0, 1'b0, 1'b1, 4'(k), 2'd3, 1'b1, 1'b0, 1'b0), rnd(),
                         (k == 4) ? (p == pass_ok) : rnd()});
      if (p == pass_ok) fin = 1'b1;
      else if (p == 3) begin fin = 1'b1; plan_err = 1'b1; end
    end
    plan.push_back('{pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b1, 1'b1, plan_err), rnd(), rnd()});
  endtask

  task automatic run_op(input logic [NB-1:0] a, input int pass_ok, input bit noise,
                        output int done_cyc, output int en_cnt);
    int passes;
    int exp_lat;
    build_plan(a, pass_ok);
    passes  = (pass_ok >= 1 && pass_ok <= 3) ? pass_ok : 3;
    exp_lat = (SKIP ? NB + $countones(a) : 2 * NB) + 5 + 5 * passes + 1;
    done_cyc = -1;
    en_cnt   = 0;
    @(negedge clk);
    checks++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, exp_err)) begin
      errors++;
      $display("FAIL idle_before_start got=%h exp=%h", obs(),
               pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, exp_err));
    end
    start = 1'b1;
    a_op  = a;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < plan.size(); k++) begin
      c_zero   = plan[k].cz;
      sub_done = plan[k].sd;
      if (noise) begin
        start = rnd();
        a_op  = NB'($urandom);
      end
      @(negedge clk);
      checks++;
      if (obs() !== plan[k].exp) begin
        errors++;
        $display("FAIL op_cycle a=%h cyc=%0d got=%h exp=%h", a, k + 1, obs(), plan[k].exp);
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = k + 1;
      if (en === 1'b1) en_cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    exp_err = plan_err;
    @(negedge clk);
    checks++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, exp_err)) begin
      errors++;
      $display("FAIL idle_after_done got=%h exp=%h", obs(),
               pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, exp_err));
    end
    checks++;
    if (done_cyc != exp_lat) begin
      errors++;
      $display("FAIL latency a=%h got=%0d exp=%0d", a, done_cyc, exp_lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_op = '0; c_zero = 1'b0; sub_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs(), pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic test_all_zero();
    int d, e;
    run_op(8'h00, 1, 1'b0, d, e);
  endtask

  task automatic test_a5();
    int d, e;
    run_op(8'hA5, 1, 1'b0, d, e);
  endtask

  task automatic test_sub_timeout();
    int d, e;
    run_op(NB'($urandom), 0, 1'b0, d, e);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_err got=%b exp=0", err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 1'b0;
    run_op(NB'($urandom), 0, 1'b0, d, e);
    run_op(NB'($urandom), 2, 1'b0, d, e);
  endtask

  task automatic test_back_to_back();
    int d, e;
    for (int i = 0; i < 6; i++)
      run_op(NB'($urandom), int'($urandom_range(1, 4)), 1'b1, d, e);
  endtask

  task automatic test_reset_mid_shift();
    logic [NB-1:0] a;
    int k = 0;
    int d, e;
    a = NB'($urandom);
    build_plan(a, 1);
    @(negedge clk);
    start = 1'b1;
    a_op  = a;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < 4 && plan[k].exp[10] !== 1'b1) begin
      c_zero = plan[k].cz;
      @(negedge clk);
      checks++;
      if (obs() !== plan[k].exp) begin
        errors++;
        $display("FAIL pre_reset_cycle cyc=%0d got=%h exp=%h", k + 1, obs(), plan[k].exp);
      end
      @(posedge clk); #1;
      k++;
    end
    c_zero = plan[k].cz;
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid_shift got=%h exp=%h", obs(), pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL after_reset_release got=%h exp=%h", obs(), pk(1'b0, 1'b0, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0));
    end
    run_op(a, 2, 1'b0, d, e);
  endtask

  task automatic test_skip_zero();
    int d, e;
    run_op(8'h01, 1, 1'b0, d, e);
    checks++;
    if (e != (SKIP ? 1 : NB)) begin
      errors++;
      $display("FAIL add_b_count got=%0d exp=%0d", e, SKIP ? 1 : NB);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_a5();
    test_sub_timeout();
    test_back_to_back();
    test_reset_mid_shift();
    test_skip_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
